mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch requester (read-only) and the memory-stage requester (read/write) of the 5-stage MIPS32 pipeline.
- Serialises the two requesters, latches request payloads, and sequences the memory handshake.
- Returns responses with a one-cycle ready pulse and drives per-stage stall lines to the pipeline control.
- Guards against a hung memory with a timeout and a sticky error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max cycles from m_req to m_valid before abort (>=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- i_req  in  1  fetch request, level; held until i_ready.
- i_addr  in  ADDR_W  fetch address, stable while i_req.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request, level; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data; 0 for stores.
- m_req  out  1  one-cycle issue pulse to memory.
- m_we  out  1  memory write enable, held while busy.
- m_addr  out  ADDR_W  memory address, held while busy.
- m_wdata  out  DATA_W  memory write data, held while busy.
- m_rdata  in  DATA_W  memory read data, valid with m_valid.
- m_valid  in  1  memory response strobe.
- m_err  in  1  memory error, sampled with m_valid.
- stall_if  out  1  i_req & ~i_ready (combinational).
- stall_mem  out  1  d_req & ~d_ready (combinational).
- err  out  1  sticky error.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state ARB_IDLE; last_grant = GNT_INST; all registered outputs 0; err 0; timeout counter 0.
- FSM: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
- ARB_IDLE grant:
  - Only i_req eligible -> BUSY_I; only d_req eligible -> BUSY_D.
  - Both eligible -> grant the requester opposite last_grant (round-robin). After reset, data wins first.
  - On grant: latch addr/we/wdata into m_* (i side: we = 0, wdata = 0), set m_req = 1 for exactly the next cycle, update last_grant, clear counter.
- Eligibility mask: in a cycle where i_ready (resp. d_ready) is high, the matching req is ignored. This prevents re-granting a held-over request. A requester must deassert req, or present a new payload, the cycle after ready.
- BUSY_x:
  - Counter increments each cycle.
  - On m_valid: next cycle pulse x_ready, x_rdata = m_rdata (d side: 0 if store), state -> IDLE. m_err with m_valid sets err; the response is still delivered.
  - Counter reaching TIMEOUT without m_valid: err <= 1, next cycle pulse x_ready with x_rdata = 0, state -> IDLE.
- Latency, req high in IDLE cycle N, memory answering one cycle after m_req:
  - N+1: m_req high.
  - N+2: m_valid high.
  - N+3: ready high.
  - Minimum total latency is 3 cycles.
- m_valid while IDLE (stray, or after mid-op reset) is ignored: no output change, no err.
- Readies are mutually exclusive and never asserted while rst is high.
- rst mid-transaction: abort immediately. No ready is issued. m_* return to 0 next cycle. Requesters re-arbitrate after reset.
- err clears only on rst.
- x_rdata holds its value until the next ready on the same side.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D};
  - typedef enum grant_t {GNT_INST, GNT_DATA};
  - default width constants.
- Sub-module arb_timeout_counter: clear/enable inputs, expired output, parameterised by TIMEOUT.

Test Plan:
- Fetch only: i_req = 1, i_addr = 0x1000, memory returns 0x2402000A one cycle after m_req -> m_req at N+1 with m_addr 0x1000 and m_we 0; i_ready at N+3 with i_rdata 0x2402000A; stall_if high N..N+2; exactly one m_req.
- Simultaneous after reset: i_req and d_req (load 0x2000) both rise in cycle N -> data granted first; fetch granted in the IDLE cycle following d_ready; next simultaneous pair -> fetch granted first (alternation).
- Store: d_req = 1, d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF -> m_we = 1, m_wdata = 0xDEADBEEF held until m_valid; d_ready pulses with d_rdata = 0; no duplicate m_req while d_req is held through the ready cycle.
- Timeout: TIMEOUT = 16, memory never returns m_valid -> at 16 cycles err = 1; i_ready pulses once with i_rdata = 0; FSM IDLE; err stays 1 through later successful accesses until rst.
- m_err: load response m_valid = 1, m_err = 1, m_rdata = 0x55 -> d_ready pulses with d_rdata = 0x55 and err = 1.
- Reset mid-op: rst in cycle after m_req, m_valid arrives 2 cycles later -> no ready pulse, err = 0, all outputs 0, stray m_valid ignored; next i_req served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the two-requester memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Arbiter FSM encoding; also visible to checkers as the top's state register.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Which requester received the most recent grant.
  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Busy-cycle counter that flags a memory access which has waited too long.
// The count restarts on clear and saturates at TIMEOUT so it never wraps.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles since the last clear, saturating at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // Expiry marks the TIMEOUT-th enabled cycle, so the abort lands on that edge.
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (read-only) and the
// memory-stage (read/write) requesters of the pipeline.
//
// Handshake semantics: x_req is a level held with a stable payload until the
// cycle x_ready pulses; in that ready cycle the request is not eligible, so
// the requester drops req or presents a new payload the cycle after.
// m_req is a one-cycle issue pulse; m_we/m_addr/m_wdata stay stable until the
// memory answers with m_valid (m_rdata/m_err qualified by it) or the access
// times out. m_valid outside a busy state is ignored.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_valid,
  input  logic              m_err,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  arb_state_t state;
  grant_t     last_grant;

  logic i_ready_q;
  logic d_ready_q;
  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;
  logic busy;
  logic expired;
  logic done;
  logic done_i;
  logic done_d;
  logic timed_out;

  // A request seen in its own ready cycle is the held-over one; mask it.
  assign i_elig = i_req & ~i_ready_q;
  assign d_elig = d_req & ~d_ready_q;

  assign busy      = (state != ARB_IDLE);
  assign done      = busy & (m_valid | expired);
  assign done_i    = done & (state == ARB_BUSY_I);
  assign done_d    = done & (state == ARB_BUSY_D);
  assign timed_out = busy & ~m_valid & expired;

  // Round-robin grant decision, only taken from the idle state.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == ARB_IDLE) begin
      if (i_elig && d_elig) begin
        if (last_grant == GNT_INST) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = i_elig;
        grant_d = d_elig;
      end
    end
  end

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_i | grant_d),
    .enable  (busy),
    .expired (expired)
  );

  // Arbiter FSM and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_INST;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            state      <= ARB_BUSY_D;
            last_grant <= GNT_DATA;
          end else if (grant_i) begin
            state      <= ARB_BUSY_I;
            last_grant <= GNT_INST;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (m_valid || expired) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory-side payload: latched on grant, held while busy, zeroed on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      m_req <= grant_i | grant_d;
      if (grant_d) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_we    <= 1'b0;
        m_addr  <= i_addr;
        m_wdata <= '0;
      end else if (done) begin
        m_we    <= 1'b0;
        m_addr  <= '0;
        m_wdata <= '0;
      end
    end
  end

  // Response pulses and read data; data holds until the next ready on that side.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ready_q <= done_i;
      d_ready_q <= done_d;
      if (done_i) begin
        i_rdata <= m_valid ? m_rdata : '0;
      end
      if (done_d) begin
        d_rdata <= (m_valid && !m_we) ? m_rdata : '0;
      end
    end
  end

  // Sticky error: memory-reported error or timeout; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((busy && m_valid && m_err) || timed_out) begin
      err <= 1'b1;
    end
  end

  // Readies are suppressed while reset is asserted.
  assign i_ready   = i_ready_q & ~rst;
  assign d_ready   = d_ready_q & ~rst;
  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus light random bench for mem_port_arbiter with a reactive
// memory model and per-side expected-response queues.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;
  logic          stall_if;
  logic          stall_mem;
  logic          err;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_valid  (m_valid),
    .m_err    (m_err),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .err      (err)
  );

  // memory model controls
  bit          mem_on = 1'b1;
  int          mem_lat = 1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  bit          fixed_err = 1'b0;
  int          stray_cycle = -1;
  int          m_req_cnt = 0;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  logic        pend_err = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: answers mem_lat cycles after each observed m_req, plus an optional stray strobe.
  always @(posedge clk) begin
    #1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_valid = 1'b1;
        m_rdata = pend_data;
        m_err   = pend_err;
      end
    end
    if (cyc == stray_cycle) begin
      m_valid = 1'b1;
      m_rdata = 32'hBAD0_BAD0;
      m_err   = 1'b1;
    end
    if (m_req === 1'b1) begin
      m_req_cnt++;
      if (mem_on) begin
        pend      = mem_lat;
        pend_data = use_fixed ? fixed_data : mem_word(m_addr);
        pend_err  = fixed_err;
      end
    end
  end

  // scoreboard
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  int total = 0;
  int passes = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ready(input bit side_d, input int budget, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < budget) begin
      tick();
      lat++;
      got = side_d ? d_ready : i_ready;
    end
    chk(side_d ? "d_ready_seen" : "i_ready_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, input int exp_lat);
    int lat;
    i_req  = 1'b1;
    i_addr = addr;
    exp_i_q.push_back(exp);
    wait_ready(1'b0, 40, lat);
    chk("i_latency", lat, exp_lat);
    chk("i_rdata", i_rdata, exp_i_q.pop_front());
    tick();
    i_req  = 1'b0;
    i_addr = '0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp, input int exp_lat);
    int lat;
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    exp_d_q.push_back(exp);
    wait_ready(1'b1, 40, lat);
    chk("d_latency", lat, exp_lat);
    chk("d_rdata", d_rdata, exp_d_q.pop_front());
    tick();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    logic [31:0] a;
    logic we;

    // reset state
    repeat (3) tick();
    chk("rst_i_ready", {31'b0, i_ready}, 32'd0);
    chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
    chk("rst_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_state", {30'b0, dut.state}, {30'b0, ARB_IDLE});
    rst = 1'b0;
    tick();

    // fetch only, cycle-exact
    use_fixed  = 1'b1;
    fixed_data = 32'h2402_000A;
    base = m_req_cnt;
    i_req  = 1'b1;
    i_addr = 32'h0000_1000;
    exp_i_q.push_back(32'h2402_000A);
    #1 chk("f_stall_n0", {31'b0, stall_if}, 32'd1);
    tick();
    chk("f_m_req_n1", {31'b0, m_req}, 32'd1);
    chk("f_m_addr_n1", m_addr, 32'h0000_1000);
    chk("f_m_we_n1", {31'b0, m_we}, 32'd0);
    chk("f_stall_n1", {31'b0, stall_if}, 32'd1);
    tick();
    chk("f_m_req_n2", {31'b0, m_req}, 32'd0);
    chk("f_i_ready_n2", {31'b0, i_ready}, 32'd0);
    chk("f_stall_n2", {31'b0, stall_if}, 32'd1);
    tick();
    chk("f_i_ready_n3", {31'b0, i_ready}, 32'd1);
    chk("f_i_rdata_n3", i_rdata, exp_i_q.pop_front());
    chk("f_stall_n3", {31'b0, stall_if}, 32'd0);
    tick();
    i_req = 1'b0;
    chk("f_i_ready_n4", {31'b0, i_ready}, 32'd0);
    chk("f_m_req_n4", {31'b0, m_req}, 32'd0);
    tick();
    chk("f_m_req_count", m_req_cnt - base, 32'd1);
    use_fixed = 1'b0;

    // simultaneous after reset: data first, then fetch
    pulse_rst();
    i_req  = 1'b1;
    i_addr = 32'h0000_1004;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_2000;
    tick();
    chk("s_m_req_first", {31'b0, m_req}, 32'd1);
    chk("s_data_first", m_addr, 32'h0000_2000);
    tick();
    tick();
    chk("s_d_ready", {31'b0, d_ready}, 32'd1);
    chk("s_d_rdata", d_rdata, mem_word(32'h0000_2000));
    chk("s_i_ready_excl", {31'b0, i_ready}, 32'd0);
    tick();
    d_req  = 1'b0;
    d_addr = '0;
    chk("s_m_req_second", {31'b0, m_req}, 32'd1);
    chk("s_fetch_second", m_addr, 32'h0000_1004);
    exp_i_q.push_back(mem_word(32'h0000_1004));
    wait_ready(1'b0, 10, lat);
    chk("s_i_latency", lat, 32'd2);
    chk("s_i_rdata", i_rdata, exp_i_q.pop_front());
    tick();
    i_req = 1'b0;

    // data alone, then a new pair goes to fetch first
    do_data(1'b0, 32'h0000_2010, 32'h0, mem_word(32'h0000_2010), 3);
    i_req  = 1'b1;
    i_addr = 32'h0000_1008;
    d_req  = 1'b1;
    d_addr = 32'h0000_2014;
    tick();
    chk("alt_fetch_first", m_addr, 32'h0000_1008);
    exp_i_q.push_back(mem_word(32'h0000_1008));
    wait_ready(1'b0, 10, lat);
    chk("alt_i_latency", lat, 32'd2);
    chk("alt_i_rdata", i_rdata, exp_i_q.pop_front());
    tick();
    i_req = 1'b0;
    chk("alt_m_req_data", {31'b0, m_req}, 32'd1);
    chk("alt_data_second", m_addr, 32'h0000_2014);
    exp_d_q.push_back(mem_word(32'h0000_2014));
    wait_ready(1'b1, 10, lat);
    chk("alt_d_latency", lat, 32'd2);
    chk("alt_d_rdata", d_rdata, exp_d_q.pop_front());
    tick();
    d_req  = 1'b0;
    d_addr = '0;

    // store with a slow memory: payload held, one m_req, zero read data
    mem_lat = 4;
    base = m_req_cnt;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_2004;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_m_req", {31'b0, m_req}, 32'd1);
    chk("st_m_we", {31'b0, m_we}, 32'd1);
    chk("st_m_addr", m_addr, 32'h0000_2004);
    chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_hold_m_req", {31'b0, m_req}, 32'd0);
      chk("st_hold_m_we", {31'b0, m_we}, 32'd1);
      chk("st_hold_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("st_hold_d_ready", {31'b0, d_ready}, 32'd0);
    end
    tick();
    chk("st_d_ready", {31'b0, d_ready}, 32'd1);
    chk("st_d_rdata", d_rdata, 32'd0);
    chk("st_m_we_cleared", {31'b0, m_we}, 32'd0);
    tick();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wdata = '0;
    chk("st_d_ready_pulse", {31'b0, d_ready}, 32'd0);
    tick();
    tick();
    chk("st_m_req_count", m_req_cnt - base, 32'd1);
    mem_lat = 1;

    // timeout: memory silent
    chk("to_err_before", {31'b0, err}, 32'd0);
    mem_on = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h0000_1100;
    exp_i_q.push_back(32'd0);
    wait_ready(1'b0, 40, lat);
    chk("to_latency", lat, TO + 1);
    chk("to_i_rdata", i_rdata, exp_i_q.pop_front());
    chk("to_err", {31'b0, err}, 32'd1);
    tick();
    i_req = 1'b0;
    chk("to_i_ready_pulse", {31'b0, i_ready}, 32'd0);
    chk("to_state_idle", {30'b0, dut.state}, {30'b0, ARB_IDLE});
    mem_on = 1'b1;
    do_fetch(32'h0000_1104, mem_word(32'h0000_1104), 3);
    chk("to_err_sticky1", {31'b0, err}, 32'd1);
    do_data(1'b0, 32'h0000_2100, 32'h0, mem_word(32'h0000_2100), 3);
    chk("to_err_sticky2", {31'b0, err}, 32'd1);
    pulse_rst();
    chk("to_err_cleared", {31'b0, err}, 32'd0);

    // memory error with a load: data still delivered
    use_fixed  = 1'b1;
    fixed_data = 32'h0000_0055;
    fixed_err  = 1'b1;
    do_data(1'b0, 32'h0000_2008, 32'h0, 32'h0000_0055, 3);
    chk("merr_err", {31'b0, err}, 32'd1);
    use_fixed = 1'b0;
    fixed_err = 1'b0;
    pulse_rst();

    // reset mid-op, then a stray m_valid while idle
    mem_on = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h0000_1200;
    stray_cycle = cyc + 4;
    tick();
    chk("rm_m_req", {31'b0, m_req}, 32'd1);
    tick();
    rst   = 1'b1;
    i_req = 1'b0;
    chk("rm_i_ready_in_rst", {31'b0, i_ready}, 32'd0);
    tick();
    rst = 1'b0;
    chk("rm_m_req_0", {31'b0, m_req}, 32'd0);
    chk("rm_m_addr_0", m_addr, 32'd0);
    chk("rm_i_ready_0", {31'b0, i_ready}, 32'd0);
    chk("rm_err_0", {31'b0, err}, 32'd0);
    chk("rm_state_idle", {30'b0, dut.state}, {30'b0, ARB_IDLE});
    tick();
    tick();
    chk("rm_stray_i_ready", {31'b0, i_ready}, 32'd0);
    chk("rm_stray_d_ready", {31'b0, d_ready}, 32'd0);
    chk("rm_stray_err", {31'b0, err}, 32'd0);
    chk("rm_stray_m_req", {31'b0, m_req}, 32'd0);
    chk("rm_stray_state", {30'b0, dut.state}, {30'b0, ARB_IDLE});
    mem_on = 1'b1;
    do_fetch(32'h0000_1204, mem_word(32'h0000_1204), 3);

    // randomised single transactions with varying memory latency
    for (int k = 0; k < 8; k++) begin
      mem_lat = $urandom_range(1, 4);
      a = {16'h0, 16'($urandom_range(0, 16'hFFFF))} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) begin
        do_fetch(a, mem_word(a), mem_lat + 2);
      end else begin
        we = 1'($urandom_range(0, 1));
        do_data(we, a, ~a, we ? 32'd0 : mem_word(a), mem_lat + 2);
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
